// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU command issuer: default sizes, opcode map and FSM encoding.
package alu_issue_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned OPW   = 3;
    localparam int unsigned DEPTH = 4;

    localparam logic [OPW-1:0] OP_000 = 3'b000;
    localparam logic [OPW-1:0] OP_001 = 3'b001;
    localparam logic [OPW-1:0] OP_010 = 3'b010;
    localparam logic [OPW-1:0] OP_011 = 3'b011;
    localparam logic [OPW-1:0] OP_100 = 3'b100;
    localparam logic [OPW-1:0] OP_101 = 3'b101;
    localparam logic [OPW-1:0] MAX_OP = OP_101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    // True for opcodes the ALU actually implements.
    function automatic logic op_known(input logic [OPW-1:0] op);
        logic known;
        known = 1'b0;
        case (op)
            OP_000, OP_001, OP_010, OP_011, OP_100, OP_101: known = 1'b1;
            default: known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO holding {op, a, b}; no bypass, head is registered storage.
module alu_cmd_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OPW   = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [OPW-1:0]   op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             pop_i,
    output logic [OPW-1:0]   op_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = OPW + 2 * WIDTH;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push_en, pop_en;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    assign {op_o, a_o, b_o} = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wr_ptr_q] <= {op_i, a_i, b_i};
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues queued commands to the combinational ALU one at a time and returns results in order.
module alu_cmd_issuer
    import alu_issue_pkg::*;
#(
    parameter int unsigned    WIDTH  = alu_issue_pkg::WIDTH,
    parameter int unsigned    OPW    = alu_issue_pkg::OPW,
    parameter int unsigned    DEPTH  = alu_issue_pkg::DEPTH,
    parameter logic [OPW-1:0] MAX_OP = alu_issue_pkg::MAX_OP
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [OPW-1:0]   cmd_op_i,
    input  logic [WIDTH-1:0] cmd_a_i,
    input  logic [WIDTH-1:0] cmd_b_i,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [OPW-1:0]   alu_select_o,
    input  logic [WIDTH-1:0] alu_result_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic [OPW-1:0]   rsp_op_o,
    output logic             rsp_err_o,
    output logic             busy_o,
    output logic [15:0]      op_count_o
);

    logic             fifo_full, fifo_empty, fifo_pop;
    logic [OPW-1:0]   fifo_op;
    logic [WIDTH-1:0] fifo_a, fifo_b;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_sel_q, alu_sel_d, op_q, op_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [OPW-1:0]   rsp_op_q, rsp_op_d;
    logic             rsp_err_q, rsp_err_d, rsp_valid_q, rsp_valid_d;
    logic [15:0]      op_count_q, op_count_d;

    alu_cmd_fifo #(
        .WIDTH (WIDTH),
        .OPW   (OPW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (cmd_valid_i),
        .op_i    (cmd_op_i),
        .a_i     (cmd_a_i),
        .b_i     (cmd_b_i),
        .pop_i   (fifo_pop),
        .op_o    (fifo_op),
        .a_o     (fifo_a),
        .b_o     (fifo_b),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign cmd_ready_o  = !fifo_full;
    assign busy_o       = (state_q != ST_IDLE) || !fifo_empty;
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_select_o = alu_sel_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_op_o     = rsp_op_q;
    assign rsp_err_o    = rsp_err_q;
    assign op_count_o   = op_count_q;

    always_comb begin
        state_d     = state_q;
        fifo_pop    = 1'b0;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        op_d        = op_q;
        err_d       = err_q;
        rsp_data_d  = rsp_data_q;
        rsp_op_d    = rsp_op_q;
        rsp_err_d   = rsp_err_q;
        rsp_valid_d = rsp_valid_q;
        op_count_d  = op_count_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rsp_data_d  = err_q ? '0 : alu_result_i;
                rsp_op_d    = op_q;
                rsp_err_d   = err_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    op_count_d  = op_count_q + 16'd1;
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Illegal opcodes still present their operands but steer the ALU to a harmless select.
        if (fifo_pop) begin
            alu_a_d   = fifo_a;
            alu_b_d   = fifo_b;
            op_d      = fifo_op;
            err_d     = !op_known(fifo_op) || (fifo_op > MAX_OP);
            alu_sel_d = err_d ? OP_000 : fifo_op;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            op_q        <= '0;
            err_q       <= 1'b0;
            rsp_data_q  <= '0;
            rsp_op_q    <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            op_q        <= op_d;
            err_q       <= err_d;
            rsp_data_q  <= rsp_data_d;
            rsp_op_q    <= rsp_op_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            op_count_q  <= op_count_d;
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: in-order response queue model, per-cycle compare, and directed scenarios.
module tb_alu_cmd_issuer;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        cmdValid = 1'b0;
    logic        cmdReady;
    logic [2:0]  cmdOp = '0;
    logic [15:0] cmdA = '0, cmdB = '0;
    logic [15:0] aluA, aluB, aluResult;
    logic [2:0]  aluSelect;
    logic        rspValid, rspReady = 1'b0;
    logic [15:0] rspData;
    logic [2:0]  rspOp;
    logic        rspErr, busy;
    logic [15:0] opCount;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] data;
        logic        err;
    } rsp_t;

    rsp_t        expQ[$];
    rsp_t        newExp;
    logic [15:0] modelCount = '0;
    int          cycle = 0;
    bit          stalled = 1'b0;
    bit          chkEn = 1'b0;
    logic [15:0] logData[$];
    logic [2:0]  logOp[$];
    logic        logErr[$];
    int          logCycle[$];
    int          passCnt = 0, totalCnt = 0;

    always #5 clk = ~clk;

    // Environment ALU: only 000 and 001 matter to the scenarios, the rest are plausible fillers.
    function automatic logic [15:0] benchAlu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            default: return 16'hDEAD;
        endcase
    endfunction

    assign aluResult = benchAlu(aluSelect, aluA, aluB);

    alu_cmd_issuer dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .cmd_valid_i  (cmdValid),
        .cmd_ready_o  (cmdReady),
        .cmd_op_i     (cmdOp),
        .cmd_a_i      (cmdA),
        .cmd_b_i      (cmdB),
        .alu_a_o      (aluA),
        .alu_b_o      (aluB),
        .alu_select_o (aluSelect),
        .alu_result_i (aluResult),
        .rsp_valid_o  (rspValid),
        .rsp_ready_i  (rspReady),
        .rsp_data_o   (rspData),
        .rsp_op_o     (rspOp),
        .rsp_err_o    (rspErr),
        .busy_o       (busy),
        .op_count_o   (opCount)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalCnt++;
        if (actual === expected) passCnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Drive one command starting at a negedge; returns at the next negedge with the accept outcome.
    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, output bit acc);
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdA     = a;
        cmdB     = b;
        acc      = cmdReady;
        @(negedge clk);
    endtask

    task automatic waitIdle(input int maxCycles, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < maxCycles; c++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clearLog();
        logData.delete();
        logOp.delete();
        logErr.delete();
        logCycle.delete();
    endtask

    // Model: every accepted command owes exactly one response, in order; each handshake counts once.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            expQ.delete();
            modelCount = '0;
            stalled    = 1'b0;
        end else begin
            cycle++;
            if (cmdValid && cmdReady) begin
                newExp.op   = cmdOp;
                newExp.err  = (cmdOp > 3'd5);
                newExp.data = newExp.err ? 16'h0 : benchAlu(cmdOp, cmdA, cmdB);
                expQ.push_back(newExp);
            end
            if (rspValid && rspReady) begin
                if (expQ.size() > 0) void'(expQ.pop_front());
                modelCount = modelCount + 16'd1;
                logData.push_back(rspData);
                logOp.push_back(rspOp);
                logErr.push_back(rspErr);
                logCycle.push_back(cycle);
            end
            stalled = rspValid && !rspReady;
        end
    end

    always @(negedge clk) begin
        if (chkEn) begin
            checkOutput("op_count", opCount, modelCount);
            checkOutput("busy", busy, expQ.size() != 0);
            if (stalled) checkOutput("rsp_held_valid", rspValid, 1);
            if (rspValid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_rsp", rspValid, 0);
                end else begin
                    checkOutput("rsp_data", rspData, expQ[0].data);
                    checkOutput("rsp_op", rspOp, expQ[0].op);
                    checkOutput("rsp_err", rspErr, expQ[0].err);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc;
        bit ok;
        bit accArr[6];
        logic [15:0] t2Exp[5];

        t2Exp[0] = 16'd101; t2Exp[1] = 16'd99; t2Exp[2] = 16'd105;
        t2Exp[3] = 16'd99;  t2Exp[4] = 16'd109;

        rstN = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_rsp_valid", rspValid, 0);
        checkOutput("rst_op_count", opCount, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_cmd_ready", cmdReady, 1);
        checkOutput("rst_alu_select", aluSelect, 0);
        checkOutput("rst_alu_a", aluA, 0);
        checkOutput("rst_rsp_data", rspData, 0);
        rstN  = 1'b1;
        chkEn = 1'b1;
        @(negedge clk);

        // Single add: latency and handshake.
        $display("[TB] scenario 1: single add");
        rspReady = 1'b1;
        applyStimulus(3'd0, 16'd9, 16'd23, acc);
        cmdValid = 1'b0;
        checkOutput("t1_accept", acc, 1);
        @(negedge clk);
        checkOutput("t1_alu_select", aluSelect, 0);
        checkOutput("t1_alu_a", aluA, 9);
        checkOutput("t1_alu_b", aluB, 23);
        checkOutput("t1_rsp_valid_early", rspValid, 0);
        @(negedge clk);
        checkOutput("t1_rsp_valid", rspValid, 1);
        checkOutput("t1_rsp_data", rspData, 32);
        checkOutput("t1_rsp_err", rspErr, 0);
        @(negedge clk);
        checkOutput("t1_op_count", opCount, 1);
        checkOutput("t1_busy", busy, 0);

        // Backpressure: capacity is DEPTH queued plus one in flight.
        $display("[TB] scenario 2: backpressure and capacity");
        rspReady = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(i[0] ? 3'd1 : 3'd0, 16'(100 + i), 16'(1 + i), acc);
            accArr[i] = acc;
        end
        cmdValid = 1'b0;
        for (int i = 0; i < 6; i++) checkOutput($sformatf("t2_accept_%0d", i), accArr[i], (i < 5) ? 1 : 0);
        repeat (4) @(negedge clk);
        checkOutput("t2_stall_valid", rspValid, 1);
        checkOutput("t2_stall_data", rspData, 101);
        checkOutput("t2_full_ready", cmdReady, 0);
        clearLog();
        rspReady = 1'b1;
        waitIdle(40, ok);
        checkOutput("t2_drain_done", ok, 1);
        checkOutput("t2_rsp_count", logData.size(), 5);
        if (logData.size() == 5)
            for (int k = 0; k < 5; k++) checkOutput($sformatf("t2_order_%0d", k), logData[k], t2Exp[k]);
        checkOutput("t2_op_count", opCount, 6);

        // Back-to-back stream with rsp_ready high.
        $display("[TB] scenario 3: streaming");
        clearLog();
        applyStimulus(3'd1, 16'd20, 16'd10, acc); checkOutput("t3_accept_0", acc, 1);
        applyStimulus(3'd0, 16'd16, 16'd16, acc); checkOutput("t3_accept_1", acc, 1);
        applyStimulus(3'd1, 16'd3, 16'd5, acc);   checkOutput("t3_accept_2", acc, 1);
        cmdValid = 1'b0;
        waitIdle(40, ok);
        checkOutput("t3_drain_done", ok, 1);
        checkOutput("t3_rsp_count", logData.size(), 3);
        if (logData.size() == 3) begin
            checkOutput("t3_data_0", logData[0], 16'd10);
            checkOutput("t3_data_1", logData[1], 16'd32);
            checkOutput("t3_data_2", logData[2], 16'hFFFE);
            checkOutput("t3_op_0", logOp[0], 1);
            checkOutput("t3_op_1", logOp[1], 0);
            checkOutput("t3_op_2", logOp[2], 1);
            checkOutput("t3_gap_1", logCycle[1] - logCycle[0], 2);
            checkOutput("t3_gap_2", logCycle[2] - logCycle[1], 2);
        end
        checkOutput("t3_op_count", opCount, 9);

        // Illegal opcode, then a legal one.
        $display("[TB] scenario 4: illegal opcode");
        clearLog();
        applyStimulus(3'd6, 16'd7, 16'd8, acc);
        cmdValid = 1'b0;
        checkOutput("t4_accept", acc, 1);
        @(negedge clk);
        checkOutput("t4_alu_select", aluSelect, 0);
        checkOutput("t4_alu_a", aluA, 7);
        checkOutput("t4_alu_b", aluB, 8);
        @(negedge clk);
        checkOutput("t4_rsp_valid", rspValid, 1);
        checkOutput("t4_rsp_err", rspErr, 1);
        checkOutput("t4_rsp_data", rspData, 0);
        checkOutput("t4_rsp_op", rspOp, 6);
        applyStimulus(3'd0, 16'd1, 16'd2, acc);
        cmdValid = 1'b0;
        waitIdle(40, ok);
        checkOutput("t4_drain_done", ok, 1);
        checkOutput("t4_rsp_count", logData.size(), 2);
        if (logData.size() == 2) begin
            checkOutput("t4_next_err", logErr[1], 0);
            checkOutput("t4_next_data", logData[1], 3);
        end
        checkOutput("t4_op_count", opCount, 11);

        // Asynchronous reset while holding a response with three queued.
        $display("[TB] scenario 5: async reset mid-operation");
        rspReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'd0, 16'(i), 16'd5, acc);
            checkOutput($sformatf("t5_accept_%0d", i), acc, 1);
        end
        cmdValid = 1'b0;
        checkOutput("t5_pre_valid", rspValid, 1);
        checkOutput("t5_pre_busy", busy, 1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("t5_rst_valid", rspValid, 0);
        checkOutput("t5_rst_busy", busy, 0);
        checkOutput("t5_rst_op_count", opCount, 0);
        checkOutput("t5_rst_cmd_ready", cmdReady, 1);
        repeat (2) @(negedge clk);
        clearLog();
        rstN     = 1'b1;
        rspReady = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("t5_no_stale", logData.size(), 0);
        checkOutput("t5_post_valid", rspValid, 0);
        checkOutput("t5_post_ready", cmdReady, 1);

        // op_count wrap from 16'hFFFF.
        $display("[TB] scenario 6: op_count wrap");
        force dut.op_count_q = 16'hFFFF;
        modelCount = 16'hFFFF;
        #1 release dut.op_count_q;
        checkOutput("t6_preload", opCount, 16'hFFFF);
        @(negedge clk);
        clearLog();
        applyStimulus(3'd0, 16'd1, 16'd1, acc);
        cmdValid = 1'b0;
        waitIdle(40, ok);
        checkOutput("t6_drain_done", ok, 1);
        checkOutput("t6_wrap", opCount, 0);
        checkOutput("t6_rsp_count", logData.size(), 1);
        if (logData.size() == 1) checkOutput("t6_data", logData[0], 2);

        chkEn = 1'b0;
        $display("[TB] %0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
